// File: rtl/multiport_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : multiport_register_file
//  Purpose  : Quadword register file with NUM_WR_PORTS write ports and
//             NUM_RD_PORTS registered read ports. The highest-index port
//             wins a write collision. Same-cycle write-to-read bypass is
//             optional. The array is zeroed by a sequenced clear engine, one
//             entry per cycle, so it can be mapped onto SRAM macros.
//  Ports    : clk_i        - single clock, all logic on posedge
//             reset_i      - synchronous active-high reset
//             rd_addr_i    - packed read addresses, port i uses slice i
//             rd_data_o    - packed registered read data, port i uses slice i
//             wr_en_i      - per-port write enable
//             wr_addr_i    - packed write addresses
//             wr_data_i    - packed write data
//             clear_req_i  - single-cycle request to zero the whole array
//             ready_o      - array usable (state RUN)
//             wr_err_o     - one-cycle pulse: a write was dropped during clear
//  Revision : 1.0 - initial release
// ============================================================================
module multiport_register_file #(
    parameter int unsigned QUADWORD       = 128,
    parameter int unsigned REG_COUNT      = 128,
    parameter int unsigned REG_ADDR_WIDTH = 7,
    parameter int unsigned NUM_WR_PORTS   = 2,
    parameter int unsigned NUM_RD_PORTS   = 6,
    parameter int unsigned BYPASS         = 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [NUM_RD_PORTS*QUADWORD-1:0]        rd_data_o,
    input  logic [NUM_WR_PORTS-1:0]                 wr_en_i,
    input  logic [NUM_WR_PORTS*REG_ADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [NUM_WR_PORTS*QUADWORD-1:0]        wr_data_i,
    input  logic                                    clear_req_i,
    output logic                                    ready_o,
    output logic                                    wr_err_o
);

    localparam logic [REG_ADDR_WIDTH-1:0] c_LAST_ENTRY = REG_ADDR_WIDTH'(REG_COUNT - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                              state_q;
    logic [REG_ADDR_WIDTH-1:0]           clr_cnt_q;
    logic                                ready_q;
    logic                                wr_err_q;
    logic [NUM_RD_PORTS*QUADWORD-1:0]    rd_data_q;
    logic [NUM_RD_PORTS*QUADWORD-1:0]    rd_data_d;
    logic [QUADWORD-1:0]                 mem_q [REG_COUNT];

    logic [REG_ADDR_WIDTH-1:0]           w_rd_addr [NUM_RD_PORTS];
    logic [REG_ADDR_WIDTH-1:0]           w_wr_addr [NUM_WR_PORTS];
    logic [QUADWORD-1:0]                 w_wr_data [NUM_WR_PORTS];

    // Addresses beyond REG_COUNT exist only when REG_COUNT is not a power of two.
    function automatic logic in_range(input logic [REG_ADDR_WIDTH-1:0] a);
        return (32'(a) < REG_COUNT);
    endfunction

    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_unpack
        assign w_rd_addr[gi] = rd_addr_i[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    end

    for (genvar gp = 0; gp < NUM_WR_PORTS; gp++) begin : g_wr_unpack
        assign w_wr_addr[gp] = wr_addr_i[gp*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign w_wr_data[gp] = wr_data_i[gp*QUADWORD +: QUADWORD];
    end

    // Read path. Ports are scanned in ascending order so the highest-index
    // matching write overrides, which is the same rule as for array writes.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            if (state_q == ST_RUN && in_range(w_rd_addr[i])) begin
                rd_data_d[i*QUADWORD +: QUADWORD] = mem_q[w_rd_addr[i]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NUM_WR_PORTS; p++) begin
                        if (wr_en_i[p] && (w_wr_addr[p] == w_rd_addr[i])) begin
                            rd_data_d[i*QUADWORD +: QUADWORD] = w_wr_data[p];
                        end
                    end
                end
            end
        end
    end

    // Array storage has no reset; the clear engine zeroes it one entry per
    // cycle. Later non-blocking assignments in the port loop win, giving
    // highest-index priority on collisions.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                for (int p = 0; p < NUM_WR_PORTS; p++) begin
                    if (wr_en_i[p] && in_range(w_wr_addr[p])) begin
                        mem_q[w_wr_addr[p]] <= w_wr_data[p];
                    end
                end
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    rd_data_q <= '0;
                    wr_err_q  <= |wr_en_i;
                    if (clr_cnt_q == c_LAST_ENTRY) begin
                        state_q   <= ST_RUN;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + REG_ADDR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    rd_data_q <= rd_data_d;
                    wr_err_q  <= 1'b0;
                    if (clear_req_i) begin
                        state_q   <= ST_CLEAR;
                        ready_q   <= 1'b0;
                        clr_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data_o = rd_data_q;
    assign ready_o   = ready_q;
    assign wr_err_o  = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multiport_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiport_register_file
//  Purpose  : Self-checking bench for multiport_register_file. Directed
//             scenarios followed by randomized traffic, all compared against
//             an array-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multiport_register_file;

    localparam int QW  = 128;
    localparam int RC  = 128;
    localparam int AW  = 7;
    localparam int NW  = 2;
    localparam int NR  = 6;
    localparam int BYP = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*QW-1:0]  rd_data;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*QW-1:0]  wr_data;
    logic              clear_req;
    logic              ready;
    logic              wr_err;

    always #5 clk = ~clk;

    multiport_register_file #(
        .QUADWORD(QW), .REG_COUNT(RC), .REG_ADDR_WIDTH(AW),
        .NUM_WR_PORTS(NW), .NUM_RD_PORTS(NR), .BYPASS(BYP)
    ) u_dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .clear_req_i(clear_req),
        .ready_o    (ready),
        .wr_err_o   (wr_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: contents, whether the array is usable, and how many
    // clear edges remain before it becomes usable.
    logic [QW-1:0] m_mem [RC];
    bit            m_run  = 1'b0;
    int            m_left = RC;
    logic          e_ready;
    logic          e_err;
    logic [QW-1:0] e_rd [NR];

    task automatic check_eq(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [QW-1:0] rnd_qw();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        wr_en     = '0;
        clear_req = 1'b0;
        for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, RC-1));
        for (int p = 0; p < NW; p++) begin
            wr_addr[p*AW +: AW] = AW'($urandom_range(0, RC-1));
            wr_data[p*QW +: QW] = rnd_qw();
        end
    endtask

    task automatic set_wr(input int p, input int a, input logic [QW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*QW +: QW] = d;
    endtask

    // Predict the outcome of the coming edge from current inputs, advance,
    // then compare every output.
    task automatic cycle();
        logic [QW-1:0] nm [RC];
        if (reset) begin
            m_run = 1'b0; m_left = RC; e_ready = 1'b0; e_err = 1'b0;
            for (int i = 0; i < NR; i++) e_rd[i] = '0;
        end else if (!m_run) begin
            e_err = |wr_en;
            for (int i = 0; i < NR; i++) e_rd[i] = '0;
            m_left--;
            if (m_left == 0) begin
                m_run = 1'b1;
                for (int a = 0; a < RC; a++) m_mem[a] = '0;
            end
            e_ready = m_run;
        end else begin
            nm = m_mem;
            for (int p = 0; p < NW; p++)
                if (wr_en[p]) nm[wr_addr[p*AW +: AW]] = wr_data[p*QW +: QW];
            for (int i = 0; i < NR; i++)
                e_rd[i] = (BYP != 0) ? nm[rd_addr[i*AW +: AW]] : m_mem[rd_addr[i*AW +: AW]];
            m_mem = nm;
            e_err = 1'b0;
            if (clear_req) begin
                m_run = 1'b0; m_left = RC;
            end
            e_ready = m_run;
        end
        @(posedge clk);
        #1;
        check_eq("ready", QW'(ready), QW'(e_ready));
        check_eq("wr_err", QW'(wr_err), QW'(e_err));
        for (int i = 0; i < NR; i++)
            check_eq($sformatf("rd_data%0d", i), rd_data[i*QW +: QW], e_rd[i]);
    endtask

    // Run idle cycles until ready; the number of edges is checked against REG_COUNT.
    task automatic wait_clear(input string tag, input int wr_at);
        int edges = 0;
        while (!ready && edges < 3*RC) begin
            idle_inputs();
            if (edges == wr_at) set_wr(0, 20, {QW/16{16'hBEEF}});
            cycle();
            edges++;
        end
        check_eq(tag, QW'(edges), QW'(RC));
    endtask

    initial begin
        logic [QW-1:0] pat_a, pat_5, pat_d, pat_1234;
        pat_a    = {QW/16{16'hAAAA}};
        pat_5    = {QW/16{16'h5555}};
        pat_d    = {QW/16{16'hDEAD}};
        pat_1234 = {QW/16{16'h1234}};
        for (int a = 0; a < RC; a++) m_mem[a] = '0;

        // Reset held for three edges, then the clear sequence with a write at
        // clear cycle 50 (must pulse wr_err and be discarded).
        reset = 1'b1;
        idle_inputs();
        repeat (3) cycle();
        reset = 1'b0;
        wait_clear("clear_len_initial", 49);

        // Every address reads back zero, including the one written during clear.
        for (int a = 0; a < RC; a += NR) begin
            idle_inputs();
            for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'((a + i) % RC);
            cycle();
        end

        // Two-port write, then read back on all ports.
        idle_inputs();
        set_wr(0, 5, pat_a);
        set_wr(1, 9, pat_5);
        cycle();
        idle_inputs();
        rd_addr = {AW'(127), AW'(0), AW'(9), AW'(5), AW'(9), AW'(5)};
        cycle();
        check_eq("basic_rd0", rd_data[0 +: QW], pat_a);
        check_eq("basic_rd1", rd_data[QW +: QW], pat_5);

        // Collision: port 1 must win.
        idle_inputs();
        set_wr(0, 12, QW'(1));
        set_wr(1, 12, QW'(2));
        cycle();
        idle_inputs();
        rd_addr[0 +: AW] = AW'(12);
        cycle();
        check_eq("collision", rd_data[0 +: QW], QW'(2));

        // Same-cycle bypass.
        idle_inputs();
        set_wr(0, 7, pat_d);
        rd_addr[0 +: AW] = AW'(7);
        cycle();
        check_eq("bypass", rd_data[0 +: QW], (BYP != 0) ? pat_d : QW'(0));

        // clear_req in RUN: same-cycle read completes, then a full clear.
        idle_inputs();
        set_wr(0, 3, pat_1234);
        cycle();
        idle_inputs();
        rd_addr[0 +: AW] = AW'(3);
        clear_req = 1'b1;
        cycle();
        check_eq("clear_req_read", rd_data[0 +: QW], pat_1234);
        wait_clear("clear_len_req", -1);
        idle_inputs();
        rd_addr[0 +: AW] = AW'(3);
        cycle();
        check_eq("after_clear_addr3", rd_data[0 +: QW], QW'(0));

        // Reset at clear cycle 64 restarts the full sequence.
        idle_inputs();
        clear_req = 1'b1;
        cycle();
        for (int k = 0; k < 64; k++) begin
            idle_inputs();
            cycle();
        end
        reset = 1'b1;
        idle_inputs();
        cycle();
        reset = 1'b0;
        wait_clear("clear_len_midreset", -1);

        // Randomized traffic on a narrow address window to force collisions
        // and bypass hits, with occasional clear requests and resets.
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            for (int p = 0; p < NW; p++) begin
                wr_en[p]            = ($urandom_range(0, 2) != 0);
                wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 15) == 0) rd_addr[0 +: AW] = AW'($urandom_range(0, RC-1));
            clear_req = ($urandom_range(0, 299) == 0);
            reset     = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
